// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access size codes,
// FSM state encoding and the default bus timeout.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and store replication for the
// outgoing command, legality check, and load extract/extend for the response.
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic        st_read,
  input  logic        st_write,
  input  logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_signed,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] ld_data,
  output logic        illegal
);

  function automatic logic [31:0] extend(input logic [15:0] v, input logic half,
                                         input logic sgn);
    if (half) return {{16{sgn & v[15]}}, v};
    else      return {{24{sgn & v[7]}}, v[7:0]};
  endfunction

  logic [31:0] shifted;

  always_comb begin
    be          = 4'b0000;
    wdata_lanes = st_wdata;
    case (st_size)
      SZ_BYTE: begin
        be          = 4'b0001 << st_addr_lo;
        wdata_lanes = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        be          = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{st_wdata[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    illegal = (st_read & st_write)
            | (st_size == SZ_RSVD)
            | ((st_size == SZ_HALF) & st_addr_lo[0])
            | ((st_size == SZ_WORD) & (st_addr_lo != 2'b00));
  end

  // Bring the addressed lane down to bit 0, then extend to a full word.
  always_comb begin
    shifted = ld_word >> {ld_addr_lo, 3'b000};
    case (ld_size)
      SZ_BYTE: ld_data = extend(shifted[15:0], 1'b0, ld_signed);
      SZ_HALF: ld_data = extend(shifted[15:0], 1'b1, ld_signed);
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one request/ack data-memory transaction per
// EX/MEM command, stalls the pipeline meanwhile and reports bad or lost accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic [31:0] EX_MEM_ALUOut,
  input  logic [31:0] EX_MEM_WriteData,
  input  logic [1:0]  EX_MEM_MemSize,
  input  logic        EX_MEM_MemSigned,
  output logic [31:0] MEM_Read_Data,
  output logic        MEM_Stall,
  output logic        MEM_Fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        is_load_q, is_load_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic [1:0]  ld_lo_q, ld_lo_d;
  logic        ld_signed_q, ld_signed_d;

  logic [3:0]  cmd_be;
  logic [31:0] cmd_wdata;
  logic [31:0] ld_data;
  logic        cmd_illegal;
  logic        cmd_valid;

  lsu_lane_align u_align (
    .st_size     (EX_MEM_MemSize),
    .st_addr_lo  (EX_MEM_ALUOut[1:0]),
    .st_read     (EX_MEM_MemRead),
    .st_write    (EX_MEM_MemWrite),
    .st_wdata    (EX_MEM_WriteData),
    .ld_size     (ld_size_q),
    .ld_addr_lo  (ld_lo_q),
    .ld_signed   (ld_signed_q),
    .ld_word     (dmem_rdata),
    .be          (cmd_be),
    .wdata_lanes (cmd_wdata),
    .ld_data     (ld_data),
    .illegal     (cmd_illegal)
  );

  assign cmd_valid = EX_MEM_MemRead | EX_MEM_MemWrite;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    fault_d     = 1'b0;
    is_load_d   = is_load_q;
    ld_size_d   = ld_size_q;
    ld_lo_d     = ld_lo_q;
    ld_signed_d = ld_signed_q;
    MEM_Stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_illegal) begin
          fault_d = 1'b1;
          rdata_d = 32'h0;
        end else if (cmd_valid) begin
          MEM_Stall   = 1'b1;
          req_d       = 1'b1;
          we_d        = EX_MEM_MemWrite;
          addr_d      = {EX_MEM_ALUOut[31:2], 2'b00};
          be_d        = cmd_be;
          wdata_d     = cmd_wdata;
          cnt_d       = 8'd0;
          is_load_d   = EX_MEM_MemRead;
          ld_size_d   = EX_MEM_MemSize;
          ld_lo_d     = EX_MEM_ALUOut[1:0];
          ld_signed_d = EX_MEM_MemSigned;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        MEM_Stall = 1'b1;
        cnt_d     = cnt_q + 8'd1;
        // An ack arriving on the last allowed cycle still completes normally.
        if (dmem_ack) begin
          req_d   = 1'b0;
          if (is_load_q) rdata_d = ld_data;
          state_d = ST_DONE;
        end else if (cnt_q + 8'd1 >= TIMEOUT_LIM) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          rdata_d = 32'h0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      fault_q     <= 1'b0;
      is_load_q   <= 1'b0;
      ld_size_q   <= SZ_BYTE;
      ld_lo_q     <= 2'b00;
      ld_signed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
      is_load_q   <= is_load_d;
      ld_size_q   <= ld_size_d;
      ld_lo_q     <= ld_lo_d;
      ld_signed_q <= ld_signed_d;
    end
  end

  assign MEM_Read_Data = rdata_q;
  assign MEM_Fault     = fault_q;
  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations,
// built with a short timeout so the no-ack path is reachable quickly.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr, sgn, ack;
  logic [31:0] addr, wd, rdata;
  logic [1:0]  size;
  logic [31:0] read_data, dmem_addr, dmem_wdata;
  logic        stall, fault, req, we;
  logic [3:0]  be;
  int          vectors = 0;
  int          miscompares = 0;
  int          nstall;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .EX_MEM_MemRead   (rd),
    .EX_MEM_MemWrite  (wr),
    .EX_MEM_ALUOut    (addr),
    .EX_MEM_WriteData (wd),
    .EX_MEM_MemSize   (size),
    .EX_MEM_MemSigned (sgn),
    .MEM_Read_Data    (read_data),
    .MEM_Stall        (stall),
    .MEM_Fault        (fault),
    .dmem_req         (req),
    .dmem_we          (we),
    .dmem_addr        (dmem_addr),
    .dmem_be          (be),
    .dmem_wdata       (dmem_wdata),
    .dmem_ack         (ack),
    .dmem_rdata       (rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic r, input logic w, input logic [1:0] sz,
                     input logic s, input logic [31:0] a, input logic [31:0] d);
    rd = r; wr = w; size = sz; sgn = s; addr = a; wd = d;
    #1;
  endtask

  task automatic no_cmd();
    cmd(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; rdata = 32'h0;
    no_cmd();
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_be", {28'h0, be}, 32'h0);

    // Word load at 0x100, ack in the first BUSY cycle.
    cmd(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    chk("lw_idle_stall", {31'h0, stall}, 32'h1);
    tick();
    chk("lw_req", {31'h0, req}, 32'h1);
    chk("lw_addr", dmem_addr, 32'h100);
    chk("lw_be", {28'h0, be}, 32'hF);
    chk("lw_we", {31'h0, we}, 32'h0);
    chk("lw_busy_stall", {31'h0, stall}, 32'h1);
    ack = 1'b1; rdata = 32'hDEADBEEF;
    tick();
    ack = 1'b0;
    chk("lw_done_stall", {31'h0, stall}, 32'h0);
    chk("lw_data", read_data, 32'hDEADBEEF);
    chk("lw_req_drop", {31'h0, req}, 32'h0);
    tick();
    no_cmd();

    // Signed then unsigned byte load at 0x203.
    for (int u = 0; u < 2; u++) begin
      cmd(1'b1, 1'b0, 2'b00, (u == 0), 32'h203, 32'h0);
      tick();
      chk("lb_be", {28'h0, be}, 32'h8);
      chk("lb_addr", dmem_addr, 32'h200);
      ack = 1'b1; rdata = 32'h80112233;
      tick();
      ack = 1'b0;
      chk(u == 0 ? "lb_signed" : "lb_unsigned", read_data,
          u == 0 ? 32'hFFFFFF80 : 32'h00000080);
      tick();
      no_cmd();
    end

    // Half store to 0x32.
    cmd(1'b0, 1'b1, 2'b01, 1'b0, 32'h32, 32'h1234ABCD);
    tick();
    chk("sh_we", {31'h0, we}, 32'h1);
    chk("sh_be", {28'h0, be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_addr", dmem_addr, 32'h30);
    ack = 1'b1; rdata = 32'h55555555;
    tick();
    ack = 1'b0;
    chk("sh_rdata_kept", read_data, 32'h00000080);
    tick();
    no_cmd();

    // Illegal commands: misaligned word, reserved size, read+write.
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       cmd(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
        1:       cmd(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
        default: cmd(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0);
      endcase
      chk("ill_stall", {31'h0, stall}, 32'h0);
      tick();
      no_cmd();
      chk("ill_fault", {31'h0, fault}, 32'h1);
      chk("ill_req", {31'h0, req}, 32'h0);
      chk("ill_rdata", read_data, 32'h0);
      tick();
      chk("ill_fault_clr", {31'h0, fault}, 32'h0);
    end

    // Word load with ack in the second BUSY cycle: three stall cycles.
    cmd(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    nstall = 0;
    for (int i = 0; i < 12; i++) begin
      if (!stall) break;
      nstall++;
      ack = (nstall == 3);
      rdata = 32'hDEADBEEF;
      tick();
    end
    ack = 1'b0;
    chk("lw2_stalls", nstall, 3);
    chk("lw2_data", read_data, 32'hDEADBEEF);
    tick();
    no_cmd();

    // Timeout with TIMEOUT_CYCLES=4 and no ack.
    cmd(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    nstall = 0;
    for (int i = 0; i < 20; i++) begin
      if (!stall) break;
      nstall++;
      tick();
    end
    chk("to_stalls", nstall, 5);
    chk("to_fault", {31'h0, fault}, 32'h1);
    chk("to_rdata", read_data, 32'h0);
    chk("to_req", {31'h0, req}, 32'h0);
    ack = 1'b1; rdata = 32'hCAFEF00D;
    tick();
    no_cmd();
    chk("to_fault_clr", {31'h0, fault}, 32'h0);
    tick();
    chk("late_ack_rdata", read_data, 32'h0);
    chk("late_ack_req", {31'h0, req}, 32'h0);
    chk("late_ack_stall", {31'h0, stall}, 32'h0);
    ack = 1'b0;

    // Reset during BUSY, ack arriving afterwards.
    cmd(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    tick();
    tick();
    chk("rb_busy_req", {31'h0, req}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    no_cmd();
    chk("rb_req", {31'h0, req}, 32'h0);
    chk("rb_stall", {31'h0, stall}, 32'h0);
    ack = 1'b1; rdata = 32'h12345678;
    tick();
    ack = 1'b0;
    chk("rb_late_rdata", read_data, 32'h0);
    chk("rb_late_req", {31'h0, req}, 32'h0);
    chk("rb_late_fault", {31'h0, fault}, 32'h0);
    chk("rb_late_stall", {31'h0, stall}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
